// File: rtl/rv_pkg.sv
// rv_pkg: shared RISC-V widths, opcodes and fetch-path entry types
package rv_pkg;
   localparam int XLEN = 32;
   localparam int INSTR_ALIGN = 2;
   localparam logic [6:0] OPCODE_LOAD  = 7'b0000011;
   localparam logic [6:0] OPCODE_STORE = 7'b0100011;
   localparam logic [6:0] OPCODE_RTYPE = 7'b0110011;
   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
   } fetch_entry_t;
   typedef struct packed {
      logic            epoch;
      logic [XLEN-1:0] pc;
   } fetch_tag_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous circular FIFO with flush, exposing its head entry and occupancy
module fetch_fifo #(
   parameter int  DEPTH = 2,
   parameter type T     = logic [63:0]
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  T                         push_data,
   input  logic                     pop,
   input  logic                     flush,
   output T                         head,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);
   T mem [DEPTH];
   logic [AW-1:0] rd_ptr, wr_ptr;
   assign head = mem[rd_ptr];
   // pointer and occupancy tracking; flush discards everything, including a same-cycle push
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         count <= count + (AW+1)'(push) - (AW+1)'(pop);
      end
   end
   // storage needs no reset: entries are only observed while count says they are valid
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= push_data;
   end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC owner and imem fetcher feeding decode through a credit-limited buffer; FETCH_PERF_EN adds perf counters
module fetch_unit
   import rv_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC  = '0,
   parameter int              BUF_DEPTH = 2
) (
   input  logic            clk,
   input  logic            rst,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_rsp_valid,
   input  logic [31:0]     imem_rsp_data,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            dec_valid,
   input  logic            dec_ready,
   output logic [31:0]     dec_instr,
   output logic [XLEN-1:0] dec_pc,
   output logic [6:0]      op_code
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0]     perf_fetched,
   output logic [31:0]     perf_redirects,
   output logic [31:0]     perf_stall
`endif
);
   localparam int CW = $clog2(BUF_DEPTH) + 1;
   logic [XLEN-1:0] pc;
   logic            epoch;
   logic [CW-1:0]   outstanding, count;
   logic            accept, rsp_take, buf_push, buf_pop;
   fetch_tag_t      tag_in, tag_head;
   fetch_entry_t    buf_in, buf_head;
   assign imem_req_valid = !rst && (({1'b0, outstanding} + {1'b0, count}) < (CW+1)'(BUF_DEPTH));
   assign imem_req_addr  = pc;
   assign accept   = imem_req_valid && imem_req_ready;
   assign rsp_take = imem_rsp_valid && outstanding != '0;
   assign buf_push = rsp_take && tag_head.epoch == epoch && !redirect_valid;
   assign dec_valid = count != '0;
   assign buf_pop   = dec_valid && dec_ready;
   assign dec_instr = dec_valid ? buf_head.instr : '0;
   assign dec_pc    = dec_valid ? buf_head.pc : '0;
   assign op_code   = dec_instr[6:0];
   assign tag_in = '{epoch: epoch, pc: pc};
   assign buf_in = '{instr: imem_rsp_data, pc: tag_head.pc};
   // pc advances per accepted request; a redirect overrides it and opens a new epoch
   always_ff @(posedge clk) begin
      if (rst) begin
         pc    <= RESET_PC;
         epoch <= 1'b0;
      end else if (redirect_valid) begin
         pc    <= {redirect_pc[XLEN-1:INSTR_ALIGN], INSTR_ALIGN'(0)};
         epoch <= ~epoch;
      end else if (accept) begin
         pc <= pc + XLEN'(4);
      end
   end
   fetch_fifo #(.DEPTH(BUF_DEPTH), .T(fetch_tag_t)) u_tags (
      .clk(clk), .rst(rst), .push(accept), .push_data(tag_in), .pop(rsp_take),
      .flush(1'b0), .head(tag_head), .count(outstanding)
   );
   fetch_fifo #(.DEPTH(BUF_DEPTH), .T(fetch_entry_t)) u_buf (
      .clk(clk), .rst(rst), .push(buf_push), .push_data(buf_in), .pop(buf_pop),
      .flush(redirect_valid), .head(buf_head), .count(count)
   );
   rsp_without_request: assert property (@(posedge clk) disable iff (rst) !(imem_rsp_valid && outstanding == '0));
`ifdef FETCH_PERF_EN
   // free-running event counters for fetch throughput analysis
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_fetched   <= '0;
         perf_redirects <= '0;
         perf_stall     <= '0;
      end else begin
         perf_fetched   <= perf_fetched + 32'(buf_pop);
         perf_redirects <= perf_redirects + 32'(redirect_valid);
         perf_stall     <= perf_stall + 32'(dec_valid && !dec_ready);
      end
   end
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scoreboard bench for fetch_unit with a variable-latency imem model
module tb_fetch_unit;
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst, imem_req_valid, imem_req_ready, imem_rsp_valid, redirect_valid, dec_valid, dec_ready;
   logic [31:0] imem_req_addr, imem_rsp_data, redirect_pc, dec_instr, dec_pc;
   logic [6:0] op_code;
   logic w_req_valid, w_rsp_valid, w_dec_valid;
   logic w_req_ready = 1'b1;
   logic w_dec_ready = 1'b1;
   logic [31:0] w_req_addr, w_rsp_data, w_dec_instr, w_dec_pc;
   logic [6:0] w_op_code;
`ifdef FETCH_PERF_EN
   logic [31:0] pf_a, pr_a, ps_a, pf_b, pr_b, ps_b;
`endif
   fetch_unit #(.RESET_PC(32'h0), .BUF_DEPTH(2)) dut (
      .clk(clk), .rst(rst), .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
      .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .dec_valid(dec_valid),
      .dec_ready(dec_ready), .dec_instr(dec_instr), .dec_pc(dec_pc), .op_code(op_code)
`ifdef FETCH_PERF_EN
      , .perf_fetched(pf_a), .perf_redirects(pr_a), .perf_stall(ps_a)
`endif
   );
   fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .BUF_DEPTH(2)) u_wrap (
      .clk(clk), .rst(rst), .imem_req_valid(w_req_valid), .imem_req_ready(w_req_ready),
      .imem_req_addr(w_req_addr), .imem_rsp_valid(w_rsp_valid), .imem_rsp_data(w_rsp_data),
      .redirect_valid(1'b0), .redirect_pc(32'h0), .dec_valid(w_dec_valid),
      .dec_ready(w_dec_ready), .dec_instr(w_dec_instr), .dec_pc(w_dec_pc), .op_code(w_op_code)
`ifdef FETCH_PERF_EN
      , .perf_fetched(pf_b), .perf_redirects(pr_b), .perf_stall(ps_b)
`endif
   );
   function automatic logic [31:0] f(input logic [31:0] a);
      return {a[29:0], 2'b11} ^ 32'hA5A5_0000;
   endfunction
   int ncmp = 0, nfail = 0, n_acc = 0, nw = 0, cyc = 0, lat = 1;
   logic [31:0] exp_req[$], exp_dec[$];
   logic [31:0] wa[3];
   typedef struct {logic [31:0] a; int due;} mreq_t;
   mreq_t mq[$];
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      ncmp++;
      assert (got === exp) else begin
         nfail++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask
   task automatic miss(input string tag, input logic [31:0] got);
      ncmp++;
      nfail++;
      $error("FAIL %s: observed %h expected nothing", tag, got);
   endtask
   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask
   task automatic wait_acc(input int target);
      int k = 0;
      while (n_acc < target && k < 50) begin
         step(1);
         k++;
      end
      chk("accept_count", n_acc, target);
   endtask
   // in-order imem model: each accepted address returns f(addr) after lat cycles
   always @(posedge clk) begin
      cyc++;
      if (rst) begin
         mq.delete();
         imem_rsp_valid <= 1'b0;
         imem_rsp_data <= '0;
      end else begin
         if (imem_rsp_valid) void'(mq.pop_front());
         if (imem_req_valid && imem_req_ready) mq.push_back('{imem_req_addr, cyc + lat});
         imem_rsp_valid <= mq.size() != 0 && mq[0].due <= cyc + 1;
         imem_rsp_data <= mq.size() != 0 ? f(mq[0].a) : '0;
      end
   end
   // single-cycle responder for the wrap instance
   always @(posedge clk) begin
      w_rsp_valid <= !rst && w_req_valid && w_req_ready;
      w_rsp_data <= 32'h0000_0013;
   end
   // scoreboard: compare accepted requests and decode pops against expectation queues
   always @(negedge clk) begin
      if (w_req_valid && w_req_ready && nw < 3) begin
         wa[nw] = w_req_addr;
         nw++;
      end
      if (!rst) begin
         if (imem_req_valid && imem_req_ready) begin
            n_acc++;
            if (exp_req.size() == 0) miss("req_extra", imem_req_addr);
            else chk("req_addr", imem_req_addr, exp_req.pop_front());
         end
         if (dec_valid && dec_ready) begin
            if (exp_dec.size() == 0) miss("dec_extra", dec_pc);
            else begin
               logic [31:0] p;
               p = exp_dec.pop_front();
               chk("dec_pc", dec_pc, p);
               chk("dec_instr", dec_instr, f(p));
               chk("op_code", {25'h0, op_code}, {25'h0, f(p) >> 0 & 32'h7F});
            end
         end
      end
   end
   initial begin
      int t;
      rst = 1'b1;
      imem_req_ready = 1'b1;
      dec_ready = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc = '0;
      step(3);
      chk("rst_dec_valid", {31'h0, dec_valid}, 32'h0);
      chk("rst_dec_instr", dec_instr, 32'h0);
      chk("rst_dec_pc", dec_pc, 32'h0);
      chk("rst_op_code", {25'h0, op_code}, 32'h0);
      chk("rst_req_valid", {31'h0, imem_req_valid}, 32'h0);
      exp_req = '{32'h0, 32'h4, 32'h8};
      exp_dec = '{32'h0, 32'h4, 32'h8};
      rst = 1'b0;
      wait_acc(3);
      imem_req_ready = 1'b0;
      step(6);
      chk("p1_req_left", exp_req.size(), 0);
      chk("p1_dec_left", exp_dec.size(), 0);
      chk("wrap0", wa[0], 32'hFFFF_FFF8);
      chk("wrap1", wa[1], 32'hFFFF_FFFC);
      chk("wrap2", wa[2], 32'h0000_0000);
      dec_ready = 1'b0;
      imem_req_ready = 1'b1;
      exp_req.push_back(32'hC);
      exp_req.push_back(32'h10);
      step(6);
      chk("bp_req_valid", {31'h0, imem_req_valid}, 32'h0);
      chk("bp_dec_valid", {31'h0, dec_valid}, 32'h1);
      chk("bp_dec_pc", dec_pc, 32'hC);
      step(3);
      chk("bp_instr_stable", dec_instr, f(32'hC));
      chk("bp_next_addr", imem_req_addr, 32'h14);
      exp_dec.push_back(32'hC);
      exp_dec.push_back(32'h10);
      exp_dec.push_back(32'h14);
      exp_req.push_back(32'h14);
      dec_ready = 1'b1;
      wait_acc(n_acc + 1);
      imem_req_ready = 1'b0;
      step(6);
      chk("p2_req_left", exp_req.size(), 0);
      chk("p2_dec_left", exp_dec.size(), 0);
      lat = 3;
      imem_req_ready = 1'b1;
      exp_req.push_back(32'h18);
      exp_req.push_back(32'h1C);
      wait_acc(n_acc + 2);
      redirect_valid = 1'b1;
      redirect_pc = 32'h100;
      exp_req.push_back(32'h100);
      exp_req.push_back(32'h104);
      exp_dec.push_back(32'h100);
      exp_dec.push_back(32'h104);
      step(1);
      redirect_valid = 1'b0;
      wait_acc(n_acc + 2);
      imem_req_ready = 1'b0;
      step(10);
      chk("p3_req_left", exp_req.size(), 0);
      chk("p3_dec_left", exp_dec.size(), 0);
      lat = 1;
      dec_ready = 1'b0;
      redirect_valid = 1'b1;
      redirect_pc = 32'h0000_0203;
      step(1);
      redirect_valid = 1'b0;
      chk("misalign_addr", imem_req_addr, 32'h200);
      chk("misalign_valid", {31'h0, imem_req_valid}, 32'h1);
      imem_req_ready = 1'b1;
      exp_req.push_back(32'h200);
      wait_acc(n_acc + 1);
      imem_req_ready = 1'b0;
      step(3);
      chk("sc_pre_dec_pc", dec_pc, 32'h200);
      chk("sc_pre_addr", imem_req_addr, 32'h204);
      exp_req.push_back(32'h204);
      exp_req.push_back(32'h300);
      exp_req.push_back(32'h304);
      exp_dec.push_back(32'h200);
      exp_dec.push_back(32'h300);
      exp_dec.push_back(32'h304);
      t = n_acc + 3;
      imem_req_ready = 1'b1;
      dec_ready = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc = 32'h300;
      step(1);
      redirect_valid = 1'b0;
      wait_acc(t);
      imem_req_ready = 1'b0;
      step(6);
      chk("sc_req_left", exp_req.size(), 0);
      chk("sc_dec_left", exp_dec.size(), 0);
      lat = 3;
      imem_req_ready = 1'b1;
      exp_req.push_back(32'h308);
      exp_req.push_back(32'h30C);
      wait_acc(n_acc + 2);
      imem_req_ready = 1'b0;
      rst = 1'b1;
      step(2);
      chk("mid_rst_dec_valid", {31'h0, dec_valid}, 32'h0);
      chk("mid_rst_req_valid", {31'h0, imem_req_valid}, 32'h0);
      rst = 1'b0;
      step(4);
      chk("post_rst_addr", imem_req_addr, 32'h0);
      chk("post_rst_valid", {31'h0, imem_req_valid}, 32'h1);
      chk("post_rst_dec_valid", {31'h0, dec_valid}, 32'h0);
      chk("end_req_left", exp_req.size(), 0);
      chk("end_dec_left", exp_dec.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end
endmodule
